// File: rtl/decoder_pkg.sv
// Shared types and helpers for the one-hot address decoder with sweep mode.
package decoder_pkg;

  // Widest decoder this package supports; narrower decoders take the low slice.
  localparam int MAX_OUT    = 256;
  localparam int MAX_ADDR_W = 8;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } sweep_state_t;

  // One-hot decode of addr over n lines; all-zero when addr is out of range.
  function automatic logic [MAX_OUT-1:0] onehot_dec(input logic [MAX_ADDR_W-1:0] addr,
                                                    input int n);
    logic [MAX_OUT-1:0] r;
    r = '0;
    if (int'(addr) < n) begin
      r[addr] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/decoder_sweep_counter.sv
// Sweep position counter: counts up from 0 and parks at NUM_OUT-1 (no wrap).
module sweep_counter #(
  parameter int NUM_OUT = 32,
  parameter int ADDR_W  = $clog2(NUM_OUT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] count,
  output logic              term
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_OUT - 1);

  assign term = (count == LAST);

  // Clear has priority over increment; increment is blocked at the last position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !term) begin
      count <= count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/decoder_sweep.sv
// Registered one-hot decoder for register-file write enables, with a
// sequential sweep mode that walks every output once for clear/init.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | decode enable/addr each cycle; sweep_start launches a sweep
// S_SWEEP | d_out walks one bit per cycle; decode inputs are ignored
module decoder_sweep
  import decoder_pkg::*;
#(
  parameter int NUM_OUT = 32,
  parameter int ADDR_W  = $clog2(NUM_OUT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [ADDR_W-1:0]  addr,
  input  logic               sweep_start,
  input  logic               sweep_abort,
  output logic [NUM_OUT-1:0] d_out,
  output logic               busy,
  output logic               sweep_done,
  output logic               addr_err
);

  sweep_state_t state, state_nxt;

  logic [ADDR_W-1:0]  cnt_q;
  logic [ADDR_W-1:0]  cnt_nxt;
  logic               cnt_term;
  logic               cnt_clr;
  logic               cnt_inc;
  logic               nxt_last;

  logic [MAX_OUT-1:0] dec_full;
  logic [NUM_OUT-1:0] d_dec;
  logic [NUM_OUT-1:0] d_sweep;
  logic [NUM_OUT-1:0] one_lsb;
  logic               in_range;
  logic               unused_dec_full;

  logic [NUM_OUT-1:0] d_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic               err_nxt;
  logic               accept_idle;

  sweep_counter #(
    .NUM_OUT (NUM_OUT),
    .ADDR_W  (ADDR_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (cnt_q),
    .term  (cnt_term)
  );

  // The package decoder is sized for the widest case; the upper lines are
  // always zero here because out-of-range addresses decode to nothing.
  assign dec_full        = onehot_dec(MAX_ADDR_W'(addr), NUM_OUT);
  assign d_dec           = dec_full[NUM_OUT-1:0];
  assign unused_dec_full = |dec_full;
  assign in_range        = ({1'b0, addr} < (ADDR_W + 1)'(NUM_OUT));

  // The counter holds the position currently on d_out, so the next sweep
  // output is one ahead of it.
  assign one_lsb  = NUM_OUT'(1);
  assign cnt_nxt  = cnt_q + ADDR_W'(1);
  assign d_sweep  = one_lsb << cnt_nxt;
  assign nxt_last = (cnt_q == ADDR_W'(NUM_OUT - 2));

  // Next-state and next-output selection for the FSM and counter controls.
  always_comb begin
    state_nxt   = state;
    d_nxt       = '0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    accept_idle = 1'b0;

    case (state)
      S_IDLE: begin
        accept_idle = 1'b1;
      end
      S_SWEEP: begin
        if (sweep_abort) begin
          state_nxt = S_IDLE;
          cnt_clr   = 1'b1;
        end else if (cnt_term) begin
          // Last one-hot has been shown; this edge already behaves as idle
          // so a decode or restart can follow with no bubble.
          accept_idle = 1'b1;
        end else begin
          d_nxt    = d_sweep;
          busy_nxt = 1'b1;
          done_nxt = nxt_last;
          cnt_inc  = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_clr   = 1'b1;
      end
    endcase

    if (accept_idle) begin
      state_nxt = S_IDLE;
      cnt_clr   = 1'b1;
      if (sweep_start) begin
        // Start wins over a simultaneous decode; this edge shows bit 0.
        state_nxt = S_SWEEP;
        d_nxt     = one_lsb;
        busy_nxt  = 1'b1;
      end else if (enable) begin
        d_nxt   = d_dec;
        err_nxt = !in_range;
      end
    end
  end

  // Register state and every output so nothing combinational reaches a port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      d_out      <= '0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      d_out      <= d_nxt;
      busy       <= busy_nxt;
      sweep_done <= done_nxt;
      addr_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_decoder_sweep.sv
// Directed bench for decoder_sweep: a 32-output and a 20-output instance share
// stimulus; each step pushes its expectation and pops it after the edge.
module tb_decoder_sweep;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [4:0]  addr;
  logic        sweep_start;
  logic        sweep_abort;

  logic [31:0] d32;
  logic        busy32, done32, err32;
  logic [19:0] d20;
  logic        busy20, done20, err20;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        sel20;
    logic [31:0] d;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  exp_t sb[$];

  decoder_sweep #(.NUM_OUT(32)) dut32 (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .addr        (addr),
    .sweep_start (sweep_start),
    .sweep_abort (sweep_abort),
    .d_out       (d32),
    .busy        (busy32),
    .sweep_done  (done32),
    .addr_err    (err32)
  );

  decoder_sweep #(.NUM_OUT(20)) dut20 (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .addr        (addr),
    .sweep_start (sweep_start),
    .sweep_abort (sweep_abort),
    .d_out       (d20),
    .busy        (busy20),
    .sweep_done  (done20),
    .addr_err    (err20)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic rs, input logic en, input logic [4:0] a,
                      input logic st, input logic ab, input logic sel,
                      input logic [31:0] ed, input logic eb, input logic edn,
                      input logic ee, input string tag);
    exp_t        e;
    exp_t        p;
    logic [31:0] od;
    logic        ob, odn, oe;
    rst_n       = rs;
    enable      = en;
    addr        = a;
    sweep_start = st;
    sweep_abort = ab;
    e.sel20 = sel;
    e.d     = ed;
    e.busy  = eb;
    e.done  = edn;
    e.err   = ee;
    sb.push_back(e);
    @(posedge clk);
    #1;
    p   = sb.pop_front();
    od  = p.sel20 ? {12'd0, d20} : d32;
    ob  = p.sel20 ? busy20 : busy32;
    odn = p.sel20 ? done20 : done32;
    oe  = p.sel20 ? err20  : err32;
    checks++;
    assert (od === p.d) else begin
      errors++;
      $error("FAIL %s d_out: observed %h expected %h", tag, od, p.d);
    end
    checks++;
    assert (ob === p.busy) else begin
      errors++;
      $error("FAIL %s busy: observed %b expected %b", tag, ob, p.busy);
    end
    checks++;
    assert (odn === p.done) else begin
      errors++;
      $error("FAIL %s sweep_done: observed %b expected %b", tag, odn, p.done);
    end
    checks++;
    assert (oe === p.err) else begin
      errors++;
      $error("FAIL %s addr_err: observed %b expected %b", tag, oe, p.err);
    end
    checks++;
    assert ($onehot0(od) === 1'b1) else begin
      errors++;
      $error("FAIL %s onehot0: observed %h expected zero or one-hot", tag, od);
    end
  endtask

  initial begin
    // Reset, both instances
    step(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, "reset32");
    step(0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, "reset20");

    // Back-to-back decodes, 32 outputs
    step(1, 1, 5'd0,  0, 0, 0, 32'h0000_0001, 0, 0, 0, "dec0");
    step(1, 1, 5'd17, 0, 0, 0, 32'h0002_0000, 0, 0, 0, "dec17");
    step(1, 1, 5'd31, 0, 0, 0, 32'h8000_0000, 0, 0, 0, "dec31");
    step(1, 0, 5'd31, 0, 0, 0, 32'h0,         0, 0, 0, "dec_off");

    // Range checking, 20 outputs
    step(1, 1, 5'd19, 0, 0, 1, 32'h0008_0000, 0, 0, 0, "rng19");
    step(1, 1, 5'd20, 0, 0, 1, 32'h0,         0, 0, 1, "rng20");
    step(1, 1, 5'd31, 0, 0, 1, 32'h0,         0, 0, 1, "rng31");
    step(1, 0, 5'd0,  0, 0, 1, 32'h0,         0, 0, 0, "rng_off");

    // Full sweep with decode held on addr 5 and a second start at cycle 10
    step(1, 1, 5'd5, 1, 0, 0, 32'h1, 1, 0, 0, "sweep_bit0");
    for (int k = 1; k < 32; k++) begin
      step(1, 1, 5'd5, (k == 10), 0, 0, 32'h1 << k, 1, (k == 31), 0,
           $sformatf("sweep_bit%0d", k));
    end
    step(1, 1, 5'd9, 0, 0, 0, 32'h0000_0200, 0, 0, 0, "post_sweep_dec9");
    step(1, 0, 5'd0, 0, 0, 0, 32'h0,         0, 0, 0, "post_sweep_idle");

    // Start colliding with a decode of 3, then abort while bit 7 is shown
    step(1, 1, 5'd3, 1, 0, 0, 32'h1, 1, 0, 0, "collide_bit0");
    for (int k = 1; k < 8; k++) begin
      step(1, 0, 5'd0, 0, 0, 0, 32'h1 << k, 1, 0, 0, $sformatf("abort_run_bit%0d", k));
    end
    step(1, 0, 5'd0, 0, 1, 0, 32'h0, 0, 0, 0, "abort");
    step(1, 1, 5'd2, 0, 0, 0, 32'h4, 0, 0, 0, "dec_after_abort");
    step(1, 0, 5'd0, 0, 0, 0, 32'h0, 0, 0, 0, "idle_after_abort");

    // Reset while bit 12 is shown, then a fresh sweep from bit 0
    step(1, 0, 5'd0, 1, 0, 0, 32'h1, 1, 0, 0, "rst_run_bit0");
    for (int k = 1; k < 13; k++) begin
      step(1, 0, 5'd0, 0, 0, 0, 32'h1 << k, 1, 0, 0, $sformatf("rst_run_bit%0d", k));
    end
    step(0, 0, 5'd0, 0, 0, 0, 32'h0, 0, 0, 0, "reset_mid_sweep");
    step(1, 0, 5'd0, 0, 0, 0, 32'h0, 0, 0, 0, "after_reset_idle");
    step(1, 0, 5'd0, 1, 0, 0, 32'h1, 1, 0, 0, "restart_bit0");
    step(1, 0, 5'd0, 0, 0, 0, 32'h2, 1, 0, 0, "restart_bit1");
    step(1, 0, 5'd0, 0, 1, 0, 32'h0, 0, 0, 0, "restart_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
